encoder_speed_averager: RTL and testbench
=========================================

Name: encoder_speed_averager

Overview:
- Sits directly downstream of the encoder high/low period measurement stage for one motor channel.
- Reconstructs complete encoder periods from that stage's count_high, count_low, count_ready and motor_is_running outputs.
- Maintains a 2^AVG_LOG2-deep moving average of period and high time.
- Flags stall when the measurement stage goes idle or samples stop arriving; the motor controller reads the averaged values.

Parameters:
- AVG_LOG2, 3, log2 of ring depth (depth = 2^AVG_LOG2, legal 1..6).
- STALL_CYCLES, 50000000, clock cycles without an accepted sample before forced flush.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- count_high  input  32  high-time count from measurement stage.
- count_low  input  32  low-time count from measurement stage.
- count_ready  input  1  high while count_high holds a final value; falls when count_low is final.
- motor_is_running  input  1  measurement stage is not idle.
- avg_period  output  32  averaged period in clk cycles.
- avg_high  output  32  averaged high time in clk cycles.
- avg_strobe  output  1  one-cycle pulse when averages update.
- avg_valid  output  1  ring is full and averages span 2^AVG_LOG2 real samples.
- stalled  output  1  no valid speed data.
- sample_count  output  AVG_LOG2+1  number of samples in ring, saturating at 2^AVG_LOG2.

Behaviour:
- Reset (reset=0, async) clears the following:
  - Outputs: avg_period=0, avg_high=0, avg_strobe=0, avg_valid=0, sample_count=0, stalled=1.
  - Internals: ring entries, running sums, timeout counter, rdy_q, high_latch, stage-1 registers.
- rdy_q registers count_ready each cycle.
- Rising detect (count_ready=1, rdy_q=0): high_latch <= count_high.
- Sample accept in cycle E requires all of: count_ready=0, rdy_q=1, motor_is_running=1.
  - A 1->0 edge with motor_is_running=0 is the idle transition. It is not a sample.
- Stage 1, end of E:
  - per_s <= high_latch + count_low, computed in 33 bits and saturated to 32'hFFFFFFFF.
  - high_s <= high_latch.
  - s1_vld <= 1.
- Stage 2, end of E+1 when s1_vld:
  - Ring write: ring_per[wr_ptr] <= per_s and ring_hi[wr_ptr] <= high_s.
  - Sums: sum_per <= sum_per - ring_per[wr_ptr] + per_s; same update for sum_hi. Sums are 32+AVG_LOG2 bits and never overflow.
  - wr_ptr increments mod 2^AVG_LOG2.
  - sample_count increments, saturating at 2^AVG_LOG2.
  - avg_period and avg_high are loaded from the new sums >> AVG_LOG2. Empty slots read as 0, so partial-fill averages are under-scaled by design.
  - avg_strobe=1 for exactly one cycle; it is visible during E+2.
  - avg_valid=1 once sample_count reaches 2^AVG_LOG2 (same edge).
  - stalled <= 0.
- Timeout counter:
  - Counts every cycle while stalled=0 and resets to 0 on each sample accept.
  - At STALL_CYCLES, a flush occurs.
  - A timeout coinciding with a sample accept: the sample wins and the counter clears.
- Flush:
  - Trigger: motor_is_running 1->0 (registered detect), or timeout.
  - Clears in one cycle: ring entries, sums, wr_ptr, sample_count, avg_period, avg_high, avg_valid, s1_vld.
  - Sets stalled=1.
  - A pending stage-1 sample is discarded.
  - Flush while stalled=1: harmless, state stays cleared.
- States:
  - STALLED (reset/flush).
  - FILLING (0 < sample_count < depth).
  - TRACKING (avg_valid=1).
  - Transitions: STALLED->FILLING on first stage-2 write; FILLING->TRACKING when the ring fills; any state->STALLED on flush.
- A new rising count_ready while stage 1 is busy is legal: high_latch is overwritten only after stage 1 has consumed it (stage 1 captures at end of E, and the next rising edge occurs no earlier than E+1).

Test Plan:
- Assert reset=0 mid-run with nonzero averages -> all outputs zero immediately (no clock needed), stalled=1, sample_count=0.
- AVG_LOG2=2; feed high=300/low=700 repeatedly:
  - Sample 1 -> avg_strobe at E+2, avg_period=250, avg_high=75, avg_valid=0, stalled=0.
  - Sample 4 -> avg_period=1000, avg_high=300, avg_valid=1.
- Continue with one high=500/low=500 sample -> avg_period=1000, avg_high=350; next three identical samples -> avg_high=500.
- Measurement stage goes idle (count_ready and motor_is_running fall in the same cycle) -> no sample accepted, flush, stalled=1, avg_period=0, avg_valid=0.
- Feed high=32'hFFFFFFF0, low=32'h100 -> per sample saturates to 32'hFFFFFFFF; sum has no wrap; with AVG_LOG2=2 after one sample avg_period=32'h3FFFFFFF.
- STALL_CYCLES=1000; after one sample hold count_ready=0 with motor_is_running=1 -> flush exactly 1000 cycles after last accept, stalled=1. Repeat with a sample landing on cycle 1000 -> no flush.

Source files
------------

// File: rtl/encoder_speed_averager.sv
// Purpose: rebuild encoder periods from high/low counts and keep a 2^AVG_LOG2-deep moving average plus a stall flag.
// Latency: an accepted sample in cycle E updates the averages at the end of E+1, and avg_strobe is high in E+2.
// Backpressure: none; one sample per count_ready fall is always absorbed, and a flush discards the pipeline.
module encoder_speed_averager #(
  parameter int AVG_LOG2     = 3,
  parameter int STALL_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         count_high,
  input  logic [31:0]         count_low,
  input  logic                count_ready,
  input  logic                motor_is_running,
  output logic [31:0]         avg_period,
  output logic [31:0]         avg_high,
  output logic                avg_strobe,
  output logic                avg_valid,
  output logic                stalled,
  output logic [AVG_LOG2:0]   sample_count
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 32 + AVG_LOG2;
  localparam int CW    = $clog2(STALL_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_STALLED  = 2'd0,
    ST_FILLING  = 2'd1,
    ST_TRACKING = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_rdy_q;
  logic                r_run_q;
  logic [31:0]         r_high_latch;
  logic [31:0]         r_per_s;
  logic [31:0]         r_high_s;
  logic                r_s1_vld;
  logic [31:0]         r_ring_per [DEPTH];
  logic [31:0]         r_ring_hi  [DEPTH];
  logic [SW-1:0]       r_sum_per;
  logic [SW-1:0]       r_sum_hi;
  logic [AVG_LOG2-1:0] r_wr_ptr;
  logic [AVG_LOG2:0]   r_sample_count;
  logic [31:0]         r_avg_per;
  logic [31:0]         r_avg_hi;
  logic                r_avg_strobe;
  logic [CW-1:0]       r_to_cnt;

  logic                w_rise;
  logic                w_accept;
  logic                w_idle;
  logic                w_counting;
  logic                w_timeout;
  logic                w_flush;
  logic [32:0]         w_per_sum33;
  logic [31:0]         w_per_sat;
  logic [SW-1:0]       w_sum_per_new;
  logic [SW-1:0]       w_sum_hi_new;
  logic [AVG_LOG2:0]   w_cnt_next;

  assign w_rise   = count_ready & ~r_rdy_q;
  assign w_accept = ~count_ready & r_rdy_q & motor_is_running;
  assign w_idle   = r_run_q & ~motor_is_running;

  // The first sample still sits in the pipeline while stalled=1, so count from s1_vld too;
  // this keeps the flush exactly STALL_CYCLES cycles after the last accept.
  assign w_counting = (r_state != ST_STALLED) | r_s1_vld;
  assign w_timeout  = w_counting & ~w_accept & (r_to_cnt == CW'(STALL_CYCLES - 1));
  assign w_flush    = w_idle | w_timeout;

  assign w_per_sum33 = {1'b0, r_high_latch} + {1'b0, count_low};
  assign w_per_sat   = w_per_sum33[32] ? 32'hFFFF_FFFF : w_per_sum33[31:0];

  assign w_sum_per_new = r_sum_per - {{AVG_LOG2{1'b0}}, r_ring_per[r_wr_ptr]} + {{AVG_LOG2{1'b0}}, r_per_s};
  assign w_sum_hi_new  = r_sum_hi  - {{AVG_LOG2{1'b0}}, r_ring_hi[r_wr_ptr]}  + {{AVG_LOG2{1'b0}}, r_high_s};
  assign w_cnt_next    = (r_sample_count == (AVG_LOG2+1)'(DEPTH)) ? r_sample_count : r_sample_count + 1'b1;

  // Edge detectors and the high-time latch taken on each rising count_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy_q      <= 1'b0;
      r_run_q      <= 1'b0;
      r_high_latch <= '0;
    end else begin
      r_rdy_q <= count_ready;
      r_run_q <= motor_is_running;
      if (w_rise) r_high_latch <= count_high;
    end
  end

  // Stage 1: form the saturated period from the latched high time and the final low time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_per_s  <= '0;
      r_high_s <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_accept & ~w_flush;
      if (w_accept) begin
        r_per_s  <= w_per_sat;
        r_high_s <= r_high_latch;
      end
    end
  end

  // Stage 2: ring write, running sums and average outputs; a flush wipes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ring_per[i] <= '0;
        r_ring_hi[i]  <= '0;
      end
      r_sum_per      <= '0;
      r_sum_hi       <= '0;
      r_wr_ptr       <= '0;
      r_sample_count <= '0;
      r_avg_per      <= '0;
      r_avg_hi       <= '0;
      r_avg_strobe   <= 1'b0;
    end else if (w_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ring_per[i] <= '0;
        r_ring_hi[i]  <= '0;
      end
      r_sum_per      <= '0;
      r_sum_hi       <= '0;
      r_wr_ptr       <= '0;
      r_sample_count <= '0;
      r_avg_per      <= '0;
      r_avg_hi       <= '0;
      r_avg_strobe   <= 1'b0;
    end else begin
      r_avg_strobe <= r_s1_vld;
      if (r_s1_vld) begin
        r_ring_per[r_wr_ptr] <= r_per_s;
        r_ring_hi[r_wr_ptr]  <= r_high_s;
        r_sum_per            <= w_sum_per_new;
        r_sum_hi             <= w_sum_hi_new;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
        r_sample_count       <= w_cnt_next;
        r_avg_per            <= w_sum_per_new[AVG_LOG2 +: 32];
        r_avg_hi             <= w_sum_hi_new[AVG_LOG2 +: 32];
      end
    end
  end

  // Stall timeout: cleared by every accepted sample, free-running while data is live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (w_flush || w_accept) begin
      r_to_cnt <= '0;
    end else if (w_counting) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_STALLED;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: flush dominates, otherwise each stage-2 write moves toward TRACKING.
  always_comb begin
    w_state_nxt = r_state;
    if (w_flush) begin
      w_state_nxt = ST_STALLED;
    end else if (r_s1_vld) begin
      if (w_cnt_next == (AVG_LOG2+1)'(DEPTH)) w_state_nxt = ST_TRACKING;
      else                                    w_state_nxt = ST_FILLING;
    end
  end

  assign avg_period   = r_avg_per;
  assign avg_high     = r_avg_hi;
  assign avg_strobe   = r_avg_strobe;
  assign avg_valid    = (r_state == ST_TRACKING);
  assign stalled      = (r_state == ST_STALLED);
  assign sample_count = r_sample_count;

endmodule

// File: tb/tb_encoder_speed_averager.sv
// Directed bench for encoder_speed_averager with AVG_LOG2=2, STALL_CYCLES=1000.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_encoder_speed_averager;

  logic        clk;
  logic        reset;
  logic [31:0] count_high;
  logic [31:0] count_low;
  logic        count_ready;
  logic        motor_is_running;
  logic [31:0] avg_period;
  logic [31:0] avg_high;
  logic        avg_strobe;
  logic        avg_valid;
  logic        stalled;
  logic [2:0]  sample_count;

  int total = 0;
  int bad   = 0;

  encoder_speed_averager #(.AVG_LOG2(2), .STALL_CYCLES(1000)) dut (
    .clk              (clk),
    .reset            (reset),
    .count_high       (count_high),
    .count_low        (count_low),
    .count_ready      (count_ready),
    .motor_is_running (motor_is_running),
    .avg_period       (avg_period),
    .avg_high         (avg_high),
    .avg_strobe       (avg_strobe),
    .avg_valid        (avg_valid),
    .stalled          (stalled),
    .sample_count     (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full encoder period: rising count_ready, hold, then fall with the low count (cycle E).
  // Returns at the negedge of E+2, where avg_strobe should be high.
  task automatic feed(input logic [31:0] hi, input logic [31:0] lo);
    @(posedge clk); #1;
    count_high  = hi;
    count_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    count_ready = 1'b0;
    count_low   = lo;
    @(negedge clk);
    check("strobe_in_E", avg_strobe, 1'b0);
    @(negedge clk);
    check("strobe_in_E1", avg_strobe, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    reset            = 1'b0;
    count_high       = '0;
    count_low        = '0;
    count_ready      = 1'b0;
    motor_is_running = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_avg_period", avg_period, 32'd0);
    check("rst_avg_high", avg_high, 32'd0);
    check("rst_strobe", avg_strobe, 1'b0);
    check("rst_valid", avg_valid, 1'b0);
    check("rst_stalled", stalled, 1'b1);
    check("rst_count", sample_count, 3'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Sample 1 of 300/700: under-scaled partial average
    feed(32'd300, 32'd700);
    check("s1_strobe", avg_strobe, 1'b1);
    check("s1_period", avg_period, 32'd250);
    check("s1_high", avg_high, 32'd75);
    check("s1_valid", avg_valid, 1'b0);
    check("s1_stalled", stalled, 1'b0);
    check("s1_count", sample_count, 3'd1);
    @(negedge clk);
    check("s1_strobe_one_cycle", avg_strobe, 1'b0);

    feed(32'd300, 32'd700);
    check("s2_period", avg_period, 32'd500);
    check("s2_count", sample_count, 3'd2);
    feed(32'd300, 32'd700);
    check("s3_period", avg_period, 32'd750);
    check("s3_valid", avg_valid, 1'b0);
    feed(32'd300, 32'd700);
    check("s4_period", avg_period, 32'd1000);
    check("s4_high", avg_high, 32'd300);
    check("s4_valid", avg_valid, 1'b1);
    check("s4_count", sample_count, 3'd4);

    // 500/500 replaces the oldest 300/700
    feed(32'd500, 32'd500);
    check("s5_period", avg_period, 32'd1000);
    check("s5_high", avg_high, 32'd350);
    check("s5_count_sat", sample_count, 3'd4);
    feed(32'd500, 32'd500);
    feed(32'd500, 32'd500);
    feed(32'd500, 32'd500);
    check("s8_period", avg_period, 32'd1000);
    check("s8_high", avg_high, 32'd500);
    check("s8_valid", avg_valid, 1'b1);

    // Idle: count_ready and motor_is_running fall together -> no sample, flush
    @(posedge clk); #1;
    count_high  = 32'd400;
    count_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    count_ready      = 1'b0;
    count_low        = 32'd600;
    motor_is_running = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_stalled", stalled, 1'b1);
    check("idle_period", avg_period, 32'd0);
    check("idle_valid", avg_valid, 1'b0);
    check("idle_count", sample_count, 3'd0);
    @(negedge clk);
    check("idle_no_strobe", avg_strobe, 1'b0);
    check("idle_period_held", avg_period, 32'd0);
    @(posedge clk); #1;
    motor_is_running = 1'b1;

    // Saturating period, then timeout flush 1000 cycles after that accept
    feed(32'hFFFF_FFF0, 32'h0000_0100);
    check("sat_period", avg_period, 32'h3FFF_FFFF);
    check("sat_high", avg_high, 32'h3FFF_FFFC);
    check("sat_count", sample_count, 3'd1);
    repeat (998) @(negedge clk);
    check("to_before_stalled", stalled, 1'b0);
    check("to_before_period", avg_period, 32'h3FFF_FFFF);
    @(negedge clk);
    check("to_flush_stalled", stalled, 1'b1);
    check("to_flush_count", sample_count, 3'd0);
    check("to_flush_period", avg_period, 32'd0);

    // Second accept lands exactly on cycle 1000 -> sample wins, no flush
    feed(32'd300, 32'd700);
    check("race_first_count", sample_count, 3'd1);
    repeat (996) @(posedge clk);
    @(posedge clk); #1;
    count_high  = 32'd300;
    count_ready = 1'b1;
    @(posedge clk); #1;
    count_ready = 1'b0;
    count_low   = 32'd700;
    @(negedge clk);
    check("race_E_stalled", stalled, 1'b0);
    @(negedge clk);
    check("race_E1_stalled", stalled, 1'b0);
    @(negedge clk);
    check("race_strobe", avg_strobe, 1'b1);
    check("race_count", sample_count, 3'd2);
    check("race_period", avg_period, 32'd500);
    check("race_stalled", stalled, 1'b0);

    // Asynchronous reset mid-run with nonzero averages
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_period", avg_period, 32'd0);
    check("arst_high", avg_high, 32'd0);
    check("arst_strobe", avg_strobe, 1'b0);
    check("arst_valid", avg_valid, 1'b0);
    check("arst_stalled", stalled, 1'b1);
    check("arst_count", sample_count, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
